// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: single-outstanding imem requests, stall hold buffer, EX redirects.
// Optional misaligned-redirect trap (HALT state) is built when FETCH_ALIGN_CHECK_EN is defined.
module fetch_stage #(
    parameter int unsigned             ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic              fetch_misaligned
);

    localparam logic [2:0] ST_ISSUE = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_DROP  = 3'd3;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       buf_instr_q, buf_instr_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic              if_valid_q, if_valid_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [ADDR_W-1:0] if_pc_plus4_q, if_pc_plus4_d;

    logic              load_new;
    logic              load_buf;
    logic [ADDR_W-1:0] target_pc;
    logic [2:0]        resume_st;     // after a redirect with nothing in flight
    logic [2:0]        drop_exit_st;  // after the discarded response returns

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [2:0] ST_HALT = 3'd4;

    logic misaligned_q, misaligned_d;
    logic bad_target;

    assign bad_target   = redirect && (redirect_pc[1:0] != 2'b00);
    assign target_pc    = redirect_pc;
    assign resume_st    = bad_target ? ST_HALT : ST_ISSUE;
    assign drop_exit_st = (bad_target || misaligned_q) ? ST_HALT : ST_ISSUE;
    assign misaligned_d = misaligned_q | bad_target;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign fetch_misaligned = misaligned_q;
`else
    logic unused_lsbs;

    assign unused_lsbs      = ^redirect_pc[1:0];
    assign target_pc        = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign resume_st        = ST_ISSUE;
    assign drop_exit_st     = ST_ISSUE;
    assign fetch_misaligned = 1'b0;
`endif

    // Request is combinational on state so it appears in the first cycle out of reset.
    assign imem_req  = rst_n && (state_q == ST_ISSUE);
    assign imem_addr = imem_req ? pc_q : '0;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        load_new    = 1'b0;
        load_buf    = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                state_d = ST_WAIT;
                if (redirect) begin
                    pc_d    = target_pc;
                    state_d = ST_DROP;
                end
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    if (redirect) begin
                        pc_d    = target_pc;
                        state_d = resume_st;
                    end else if (!stall) begin
                        load_new = 1'b1;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = ST_ISSUE;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = pc_q;
                        pc_d        = pc_q + PC_STEP;
                        state_d     = ST_HOLD;
                    end
                end else if (redirect) begin
                    pc_d    = target_pc;
                    state_d = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    buf_instr_d = '0;
                    buf_pc_d    = '0;
                    pc_d        = target_pc;
                    state_d     = resume_st;
                end else if (!stall) begin
                    load_buf = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    pc_d = target_pc;
                end
                if (imem_valid) begin
                    state_d = drop_exit_st;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_ISSUE;
            end
        endcase
    end

    // IF/ID: redirect beats stall, stall beats any load, otherwise bubble.
    always_comb begin
        if_valid_d    = 1'b0;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if (redirect) begin
            if_valid_d = 1'b0;
        end else if (stall) begin
            if_valid_d = if_valid_q;
        end else if (load_new) begin
            if_valid_d    = 1'b1;
            if_instr_d    = imem_rdata;
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_q + PC_STEP;
        end else if (load_buf) begin
            if_valid_d    = 1'b1;
            if_instr_d    = buf_instr_q;
            if_pc_d       = buf_pc_q;
            if_pc_plus4_d = buf_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_ISSUE;
            pc_q          <= RESET_PC;
            buf_instr_q   <= '0;
            buf_pc_q      <= '0;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency instruction memory returning addr ^ 32'hA5A5_0000.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        fetch_misaligned;

    int checks   = 0;
    int failures = 0;

    int unsigned mem_lat = 1;
    int unsigned mem_cnt = 0;
    logic [31:0] mem_addr;

    fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_valid       (imem_valid),
        .imem_rdata       (imem_rdata),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .if_valid         (if_valid),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .if_pc_plus4      (if_pc_plus4),
        .fetch_misaligned (fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: response strobe exactly mem_lat cycles after the request cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_cnt    <= 0;
            imem_valid <= 1'b0;
            imem_rdata <= '0;
        end else begin
            imem_valid <= 1'b0;
            if (imem_req) begin
                mem_addr <= imem_addr;
                if (mem_lat <= 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= imem_addr ^ 32'hA5A5_0000;
                    mem_cnt    <= 0;
                end else begin
                    mem_cnt <= mem_lat - 1;
                end
            end else if (mem_cnt != 0) begin
                mem_cnt <= mem_cnt - 1;
                if (mem_cnt == 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= mem_addr ^ 32'hA5A5_0000;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && imem_req) $display("req  addr=%h", imem_addr);
        if (rst_n && if_valid) $display("ifid pc=%h instr=%h", if_pc, if_instr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned lat);
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_lat = lat;
        step(); step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_lat = 1;
        step(); step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", if_instr); end
        checks++; if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h/%h exp=0/0", if_pc, if_pc_plus4); end
        checks++; if (fetch_misaligned !== 1'b0) begin failures++; $display("FAIL rst_misal got=%b exp=0", fetch_misaligned); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rst_first_req got=%b@%h exp=1@0", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] pc;
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            pc = 32'(k * 4);
            checks++; if (imem_req !== 1'b1 || imem_addr !== pc) begin failures++; $display("FAIL seq_req got=%b@%h exp=1@%h", imem_req, imem_addr, pc); end
            step();
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL seq_wait_req got=%b exp=0", imem_req); end
            step();
            checks++; if (if_valid !== 1'b1 || if_pc !== pc || if_pc_plus4 !== pc + 32'd4) begin
                failures++; $display("FAIL seq_ifid got=%b %h/%h exp=1 %h/%h", if_valid, if_pc, if_pc_plus4, pc, pc + 32'd4); end
            checks++; if (if_instr !== (pc ^ 32'hA5A5_0000)) begin failures++; $display("FAIL seq_instr got=%h exp=%h", if_instr, pc ^ 32'hA5A5_0000); end
        end
    endtask

    task automatic test_stall();
        do_reset(3);
        repeat (8) step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL stall_req8 got=%b@%h exp=1@8", imem_req, imem_addr); end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'hA5A5_0004) begin
                failures++; $display("FAIL stall_hold got=%b %h %h exp=1 4 a5a50004", if_valid, if_pc, if_instr); end
            if (i >= 1) begin
                checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_noreq got=%b exp=0", imem_req); end
            end
            step();
        end
        stall = 1'b0;
        checks++; if (if_pc !== 32'h4 || imem_req !== 1'b0) begin failures++; $display("FAIL stall_fall got=%h req=%b exp=4 req=0", if_pc, imem_req); end
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_pc_plus4 !== 32'hC || if_instr !== 32'hA5A5_0008) begin
            failures++; $display("FAIL stall_release got=%b %h/%h %h exp=1 8/c a5a50008", if_valid, if_pc, if_pc_plus4, if_instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin failures++; $display("FAIL stall_next_req got=%b@%h exp=1@c", imem_req, imem_addr); end
    endtask

    task automatic test_redirect();
        do_reset(3);
        repeat (4) step();
        stall = 1'b1;
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin failures++; $display("FAIL redir_pre got=%b %h exp=1 0", if_valid, if_pc); end
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL redir_clear got=%b req=%b exp=0 req=0", if_valid, imem_req); end
        step();
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL redir_drop got=%b req=%b exp=0 req=0", if_valid, imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL redir_req got=%b@%h exp=1@100", imem_req, imem_addr); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_stale got=%b pc=%h exp=0", if_valid, if_pc); end
            if (i < 3) step();
        end
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'hA5A5_0100) begin
            failures++; $display("FAIL redir_target got=%b %h %h exp=1 100 a5a50100", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_redirect_stall();
        do_reset(1);
        step(); step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin failures++; $display("FAIL rs_pre got=%b %h exp=1 0", if_valid, if_pc); end
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0; stall = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rs_clear got=%b req=%b exp=0 req=0", if_valid, imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL rs_req got=%b@%h exp=1@200", imem_req, imem_addr); end
        step(); step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'hA5A5_0200) begin
            failures++; $display("FAIL rs_target got=%b %h %h exp=1 200 a5a50200", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_wrap();
        do_reset(1);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req got=%b@%h exp=1@fffffffc", imem_req, imem_addr); end
        step(); step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin
            failures++; $display("FAIL wrap_ifid got=%b %h/%h exp=1 fffffffc/0", if_valid, if_pc, if_pc_plus4); end
        checks++; if (if_instr !== 32'h5A5A_FFFC) begin failures++; $display("FAIL wrap_instr got=%h exp=5a5afffc", if_instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%b@%h exp=1@0", imem_req, imem_addr); end
    endtask

    task automatic test_misalign();
        do_reset(1);
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (fetch_misaligned !== 1'b1 || if_valid !== 1'b0) begin failures++; $display("FAIL mis_flag got=%b v=%b exp=1 v=0", fetch_misaligned, if_valid); end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (imem_req !== 1'b0 || fetch_misaligned !== 1'b1) begin failures++; $display("FAIL mis_halt got=%b flag=%b exp=0 flag=1", imem_req, fetch_misaligned); end
        end
        rst_n = 1'b0;
        step();
        checks++; if (fetch_misaligned !== 1'b0) begin failures++; $display("FAIL mis_reset got=%b exp=0", fetch_misaligned); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL mis_restart got=%b@%h exp=1@0", imem_req, imem_addr); end
`else
        checks++; if (fetch_misaligned !== 1'b0) begin failures++; $display("FAIL mis_flag got=%b exp=0", fetch_misaligned); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL mis_align got=%b@%h exp=1@100", imem_req, imem_addr); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset(3);
        step();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mid_wait got=%b exp=0", imem_req); end
        do_reset(3);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
            failures++; $display("FAIL mid_restart got=%b@%h v=%b exp=1@0 v=0", imem_req, imem_addr, if_valid); end
        repeat (4) step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hA5A5_0000) begin
            failures++; $display("FAIL mid_ifid got=%b %h %h exp=1 0 a5a50000", if_valid, if_pc, if_instr); end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the core. Holds the PC and issues single-outstanding requests to instruction memory. Delivers instruction, PC and PC+4 to decode, where the control unit consumes the op/func3/func11 fields and the PC+4 feeds the `jump`/`jll`/`jlrl` link result. Applies stalls from the hazard unit and redirects from jump resolution in EX.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `ADDR_W`, default 32: PC/address width.
- `clk` in 1: sole clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_req` out 1: one-cycle request pulse.
- `imem_addr` out ADDR_W: request address, valid with `imem_req`.
- `imem_valid` in 1: response strobe, ≥1 cycle after `imem_req`.
- `imem_rdata` in 32: instruction word, valid with `imem_valid`.
- `stall` in 1: decode cannot accept; hold IF/ID contents.
- `redirect` in 1: taken jump/branch resolved in EX.
- `redirect_pc` in ADDR_W: target PC when `redirect`=1.
- `if_valid` out 1: IF/ID holds a live instruction.
- `if_instr` out 32: instruction to decode.
- `if_pc` out ADDR_W: address of `if_instr`.
- `if_pc_plus4` out ADDR_W: `if_pc`+4, modulo 2^ADDR_W.
- `fetch_misaligned` out 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- States: ISSUE, WAIT, HOLD, DROP, plus HALT under the macro.
- One request outstanding at most. Memory accepts every request and returns exactly one response per request.
- ISSUE: `imem_req`=1, `imem_addr`=pc. Next state: WAIT. If `redirect` is asserted this cycle: pc<=`redirect_pc`, next state DROP.
- WAIT with `imem_valid` and `redirect`: discard the response, pc<=`redirect_pc`, next state ISSUE.
- WAIT with `imem_valid` and `stall`=0: load IF/ID with {rdata, pc, pc+4}, set `if_valid`=1, pc<=pc+4, next state ISSUE.
- WAIT with `imem_valid` and `stall`=1: capture the response in a one-entry hold buffer, pc<=pc+4, next state HOLD.
- WAIT without `imem_valid` but with `redirect`: pc<=`redirect_pc`, next state DROP.
- HOLD with `redirect`: clear the buffer, pc<=`redirect_pc`, next state ISSUE.
- HOLD with `stall`=0: move the buffer into IF/ID with `if_valid`=1, next state ISSUE.
- DROP: wait for `imem_valid` and discard it; a further `redirect` overwrites pc. On `imem_valid`, next state ISSUE.
- IF/ID priority, highest first: reset, `redirect` (`if_valid`<=0), `stall` (hold all fields), new load, bubble (`if_valid`<=0).
- PC arithmetic is unsigned and wraps at 2^ADDR_W. For example, 32'hFFFF_FFFC+4 gives 0.
- `imem_valid` in ISSUE or HOLD is a protocol violation and is ignored.

## Timing
- Reset values: all outputs 0; pc=`RESET_PC`; state ISSUE. The first `imem_req` occurs in the first cycle after `rst_n` rises.
- Reset asserted mid-request: state returns to ISSUE and no DROP is entered. The memory must also be reset in the same cycle.
- Latency from `imem_req` to `if_valid`: L+1 cycles, where L is the memory latency.
- Throughput: one instruction per L+1 cycles.
- `redirect` takes effect in one cycle: `if_valid`=0 on the next edge, and the request to `redirect_pc` issues no later than one cycle after the pending response returns.
- `redirect` and `stall` in the same cycle: `redirect` wins.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A `redirect` with `redirect_pc[1:0]`≠0 sets `fetch_misaligned`=1 next cycle.
  - Clears `if_valid`, drops any outstanding response, then enters HALT.
  - HALT issues no requests and is left only by reset.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `redirect_pc[1:0]` is forced to 0.
  - `fetch_misaligned` is tied to 0.
  - HALT is not built.

## Test plan
- Reset, `RESET_PC`=0, fixed L=1 memory returning addr^32'hA5A5_0000 -> requests at 0,4,8 every 2 cycles; `if_pc`/`if_pc_plus4` = 0/4, 4/8, 8/12; matching `if_instr`.
- `stall` held 5 cycles while an L=3 response arrives for pc 8 -> instruction at pc 4 held in IF/ID; pc 8 appears one cycle after `stall` falls; no new `imem_req` during HOLD.
- `redirect` to 32'h100 in WAIT with L=3 -> response for the old pc discarded; `if_valid`=0 next cycle; next `imem_req` at 32'h100; no instruction at old pc+4 ever reaches decode.
- `redirect` and `stall` together while `if_valid`=1 -> `if_valid`=0 next cycle and fetch resumes at target.
- pc=32'hFFFF_FFFC with L=1 -> `if_pc_plus4`=0; next `imem_addr`=0.
- With `FETCH_ALIGN_CHECK_EN`, `redirect_pc`=32'h102 -> `fetch_misaligned`=1; no `imem_req` thereafter until `rst_n`=0. Without the macro -> next `imem_addr`=32'h100.
